// File: rtl/vdp_reg_arbiter.sv
// Shares the VDP register-file write port between a FIFO-buffered host path
// and a one-entry copper holding register; copper wins unless the host is starving.
module vdp_reg_arbiter #(
  parameter int HOST_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               host_write_en,
  input  logic [5:0]                         host_address,
  input  logic [15:0]                        host_data,
  output logic                               host_ready,
  output logic                               host_overflow,
  output logic [$clog2(HOST_FIFO_DEPTH):0]   host_fifo_level,
  input  logic                               copper_write_en,
  input  logic [5:0]                         copper_address,
  input  logic [15:0]                        copper_data,
  output logic                               copper_ready,
  input  logic                               reg_busy,
  output logic                               reg_write_en,
  output logic [5:0]                         reg_write_address,
  output logic [15:0]                        reg_write_data,
  output logic                               reg_write_from_copper
);

  localparam int PTR_W = $clog2(HOST_FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(HOST_FIFO_DEPTH);
  localparam logic [7:0]       STARVE_MAX = 8'(STARVE_LIMIT);

  logic [21:0]      fifo_mem [HOST_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             hold_valid;
  logic [5:0]       hold_address;
  logic [15:0]      hold_data;
  logic [7:0]       starve_cnt;

  logic             fifo_empty;
  logic             push;
  logic             capture;
  logic             grant_copper;
  logic             grant_host;
  logic [LVL_W-1:0] level_next;

  // Grants are decided purely from registered state plus reg_busy.
  assign fifo_empty   = (host_fifo_level == '0);
  assign push         = host_write_en && host_ready;
  assign capture      = copper_write_en && copper_ready;
  assign grant_copper = !reg_busy && hold_valid && (fifo_empty || starve_cnt != STARVE_MAX);
  assign grant_host   = !reg_busy && !fifo_empty && !grant_copper;
  assign level_next   = host_fifo_level + LVL_W'(push) - LVL_W'(grant_host);

  // NOTE: payload storage has no reset; level and hold_valid alone say what is live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {host_address, host_data};
    if (capture) begin
      hold_address <= copper_address;
      hold_data    <= copper_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      host_fifo_level       <= '0;
      host_ready            <= 1'b1;
      host_overflow         <= 1'b0;
      hold_valid            <= 1'b0;
      copper_ready          <= 1'b1;
      starve_cnt            <= '0;
      reg_write_en          <= 1'b0;
      reg_write_address     <= '0;
      reg_write_data        <= '0;
      reg_write_from_copper <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (grant_host) rd_ptr <= rd_ptr + PTR_W'(1);
      if (host_write_en && !host_ready) host_overflow <= 1'b1;
      host_fifo_level <= level_next;
      host_ready      <= (level_next != FULL_LEVEL);

      reg_write_en <= grant_copper || grant_host;
      if (grant_copper) begin
        reg_write_address     <= hold_address;
        reg_write_data        <= hold_data;
        reg_write_from_copper <= 1'b1;
      end else if (grant_host) begin
        {reg_write_address, reg_write_data} <= fifo_mem[rd_ptr];
        reg_write_from_copper <= 1'b0;
      end

      // Capture only happens when empty and a copper grant only when full, so they never collide.
      hold_valid   <= capture || (hold_valid && !grant_copper);
      copper_ready <= !(capture || (hold_valid && !grant_copper));

      if (fifo_empty || grant_host) starve_cnt <= '0;
      else if (grant_copper && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vdp_reg_arbiter.sv
// Self-checking bench for vdp_reg_arbiter: constant vector table, hand-written
// corner sequences, then randomized traffic against a queue-based reference model.
module tb_vdp_reg_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          host_write_en;
  logic [5:0]    host_address;
  logic [15:0]   host_data;
  logic          host_ready;
  logic          host_overflow;
  logic [LW-1:0] host_fifo_level;
  logic          copper_write_en;
  logic [5:0]    copper_address;
  logic [15:0]   copper_data;
  logic          copper_ready;
  logic          reg_busy;
  logic          reg_write_en;
  logic [5:0]    reg_write_address;
  logic [15:0]   reg_write_data;
  logic          reg_write_from_copper;

  vdp_reg_arbiter #(.HOST_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .host_write_en(host_write_en), .host_address(host_address), .host_data(host_data),
    .host_ready(host_ready), .host_overflow(host_overflow), .host_fifo_level(host_fifo_level),
    .copper_write_en(copper_write_en), .copper_address(copper_address), .copper_data(copper_data),
    .copper_ready(copper_ready), .reg_busy(reg_busy),
    .reg_write_en(reg_write_en), .reg_write_address(reg_write_address),
    .reg_write_data(reg_write_data), .reg_write_from_copper(reg_write_from_copper)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The copper must never strobe while its holding register is occupied.
  always @(posedge clk)
    assert (reset || !(copper_write_en && !copper_ready)) else $error("copper strobed while not ready");

  // Reference model: a queue for the FIFO, a single slot for the copper, a starvation tally.
  logic [21:0] m_q[$];
  logic        m_hold_v = 1'b0;
  logic [21:0] m_hold;
  int          m_cnt = 0;
  logic        m_we = 1'b0;
  logic [5:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic        m_src = 1'b0;
  logic        m_ovf = 1'b0;

  task automatic model_step();
    logic fifo_ne, hold_pre, full_pre, g_c, g_h;
    if (reset) begin
      m_q.delete();
      m_hold_v = 1'b0; m_cnt = 0; m_we = 1'b0;
      m_addr = '0; m_data = '0; m_src = 1'b0; m_ovf = 1'b0;
      return;
    end
    fifo_ne  = (m_q.size() > 0);
    hold_pre = m_hold_v;
    full_pre = (m_q.size() == DEPTH);
    g_c = 1'b0;
    g_h = 1'b0;
    if (!reg_busy) begin
      if (hold_pre && !(fifo_ne && m_cnt == LIMIT)) g_c = 1'b1;
      else if (fifo_ne) g_h = 1'b1;
    end
    m_we = g_c || g_h;
    if (g_c) begin {m_addr, m_data} = m_hold; m_src = 1'b1; m_hold_v = 1'b0; end
    if (g_h) begin {m_addr, m_data} = m_q.pop_front(); m_src = 1'b0; end
    if (!fifo_ne || g_h) m_cnt = 0;
    else if (g_c) m_cnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
    if (host_write_en) begin
      if (full_pre) m_ovf = 1'b1;
      else m_q.push_back({host_address, host_data});
    end
    if (copper_write_en && !hold_pre) begin
      m_hold   = {copper_address, copper_data};
      m_hold_v = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic hw, input logic [5:0] ha, input logic [15:0] hd,
                       input logic cw, input logic [5:0] ca, input logic [15:0] cd, input logic busy);
    host_write_en = hw; host_address = ha; host_data = hd;
    copper_write_en = cw; copper_address = ca; copper_data = cd;
    reg_busy = busy;
  endtask

  task automatic check_model();
    check("rnd_we", reg_write_en, m_we);
    check("rnd_addr", reg_write_address, m_addr);
    check("rnd_data", reg_write_data, m_data);
    if (m_we) check("rnd_src", reg_write_from_copper, m_src);
    check("rnd_host_ready", host_ready, (m_q.size() != DEPTH));
    check("rnd_copper_ready", copper_ready, !m_hold_v);
    check("rnd_level", host_fifo_level, m_q.size());
    check("rnd_overflow", host_overflow, m_ovf);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"}, reg_write_en, 0);
    check({tag, "_addr"}, reg_write_address, 0);
    check({tag, "_data"}, reg_write_data, 0);
    check({tag, "_src"}, reg_write_from_copper, 0);
    check({tag, "_host_ready"}, host_ready, 1);
    check({tag, "_copper_ready"}, copper_ready, 1);
    check({tag, "_overflow"}, host_overflow, 0);
    check({tag, "_level"}, host_fifo_level, 0);
  endtask

  typedef struct {
    logic        hw;
    logic [5:0]  ha;
    logic [15:0] hd;
    logic        cw;
    logic [5:0]  ca;
    logic [15:0] cd;
    logic        busy;
    logic        e_we;
    logic [5:0]  e_addr;
    logic [15:0] e_data;
    logic        e_src;
    logic        e_hr;
    logic        e_cr;
    logic [2:0]  e_lvl;
  } vec_t;

  function automatic vec_t mk(input logic hw, input logic [5:0] ha, input logic [15:0] hd,
                              input logic cw, input logic [5:0] ca, input logic [15:0] cd,
                              input logic busy, input logic e_we, input logic [5:0] e_addr,
                              input logic [15:0] e_data, input logic e_src, input logic e_hr,
                              input logic e_cr, input logic [2:0] e_lvl);
    vec_t v;
    v.hw = hw; v.ha = ha; v.hd = hd; v.cw = cw; v.ca = ca; v.cd = cd; v.busy = busy;
    v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data; v.e_src = e_src;
    v.e_hr = e_hr; v.e_cr = e_cr; v.e_lvl = e_lvl;
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    int writes;
    // Each row: inputs for one cycle, then the outputs expected in the following cycle.
    vecs[0]  = mk(1, 6'h05, 16'h1234, 0, 6'h00, 16'h0000, 0,  0, 6'h00, 16'h0000, 0, 1, 1, 3'd1);
    vecs[1]  = mk(1, 6'h06, 16'h5678, 0, 6'h00, 16'h0000, 0,  1, 6'h05, 16'h1234, 0, 1, 1, 3'd1);
    vecs[2]  = mk(1, 6'h07, 16'h9ABC, 0, 6'h00, 16'h0000, 0,  1, 6'h06, 16'h5678, 0, 1, 1, 3'd1);
    vecs[3]  = mk(0, 6'h00, 16'h0000, 0, 6'h00, 16'h0000, 0,  1, 6'h07, 16'h9ABC, 0, 1, 1, 3'd0);
    vecs[4]  = mk(0, 6'h00, 16'h0000, 0, 6'h00, 16'h0000, 0,  0, 6'h07, 16'h9ABC, 0, 1, 1, 3'd0);
    vecs[5]  = mk(1, 6'h01, 16'h1111, 0, 6'h00, 16'h0000, 1,  0, 6'h07, 16'h9ABC, 0, 1, 1, 3'd1);
    vecs[6]  = mk(1, 6'h02, 16'h2222, 0, 6'h00, 16'h0000, 1,  0, 6'h07, 16'h9ABC, 0, 1, 1, 3'd2);
    vecs[7]  = mk(0, 6'h00, 16'h0000, 1, 6'h10, 16'hBEEF, 1,  0, 6'h07, 16'h9ABC, 0, 1, 0, 3'd2);
    vecs[8]  = mk(0, 6'h00, 16'h0000, 0, 6'h00, 16'h0000, 0,  1, 6'h10, 16'hBEEF, 1, 1, 1, 3'd2);
    vecs[9]  = mk(0, 6'h00, 16'h0000, 0, 6'h00, 16'h0000, 0,  1, 6'h01, 16'h1111, 0, 1, 1, 3'd1);
    vecs[10] = mk(0, 6'h00, 16'h0000, 0, 6'h00, 16'h0000, 0,  1, 6'h02, 16'h2222, 0, 1, 1, 3'd0);
    vecs[11] = mk(0, 6'h00, 16'h0000, 0, 6'h00, 16'h0000, 0,  0, 6'h02, 16'h2222, 0, 1, 1, 3'd0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    check_reset_values("reset");
    tick();
    reset = 1'b0;

    // Host-only burst followed by copper priority over two queued host writes.
    foreach (vecs[i]) begin
      drive(vecs[i].hw, vecs[i].ha, vecs[i].hd, vecs[i].cw, vecs[i].ca, vecs[i].cd, vecs[i].busy);
      tick();
      check($sformatf("vec%0d_we", i), reg_write_en, vecs[i].e_we);
      check($sformatf("vec%0d_addr", i), reg_write_address, vecs[i].e_addr);
      check($sformatf("vec%0d_data", i), reg_write_data, vecs[i].e_data);
      if (vecs[i].e_we) check($sformatf("vec%0d_src", i), reg_write_from_copper, vecs[i].e_src);
      check($sformatf("vec%0d_host_ready", i), host_ready, vecs[i].e_hr);
      check($sformatf("vec%0d_copper_ready", i), copper_ready, vecs[i].e_cr);
      check($sformatf("vec%0d_level", i), host_fifo_level, vecs[i].e_lvl);
      check($sformatf("vec%0d_overflow", i), host_overflow, 0);
    end

    // Starvation with STARVE_LIMIT=2: copper, copper, host, copper.
    drive(1, 6'h3A, 16'hAAAA, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 1, 6'h20, 16'hC001, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    check("starve_g1_we", reg_write_en, 1);
    check("starve_g1_src", reg_write_from_copper, 1);
    check("starve_g1_addr", reg_write_address, 6'h20);
    drive(0, 0, 0, 1, 6'h21, 16'hC002, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    check("starve_g2_src", reg_write_from_copper, 1);
    check("starve_g2_addr", reg_write_address, 6'h21);
    drive(0, 0, 0, 1, 6'h22, 16'hC003, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    check("starve_g3_we", reg_write_en, 1);
    check("starve_g3_src", reg_write_from_copper, 0);
    check("starve_g3_addr", reg_write_address, 6'h3A);
    check("starve_g3_data", reg_write_data, 16'hAAAA);
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    check("starve_g4_src", reg_write_from_copper, 1);
    check("starve_g4_addr", reg_write_address, 6'h22);
    // A fresh contention must favour copper again once the tally has cleared.
    drive(1, 6'h3B, 16'hBBBB, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 1, 6'h23, 16'hC004, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    check("starve_clr_src", reg_write_from_copper, 1);
    check("starve_clr_addr", reg_write_address, 6'h23);
    tick();
    check("starve_clr_host", reg_write_address, 6'h3B);
    tick();

    // Fill under reg_busy, overflow on the fifth strobe, then drain in order.
    for (int i = 0; i < 5; i++) begin
      drive(1, 6'(6'h30 + i), 16'(16'hA000 + i), 0, 0, 0, 1);
      tick();
      if (i == 2) check("full_ready_before", host_ready, 1);
      if (i == 3) check("full_ready_low", host_ready, 0);
      if (i == 4) begin
        check("full_overflow", host_overflow, 1);
        check("full_level", host_fifo_level, 4);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    writes = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) check("full_ready_back", host_ready, 1);
      if (reg_write_en) begin
        check($sformatf("drain%0d_addr", writes), reg_write_address, 6'h30 + writes);
        check($sformatf("drain%0d_data", writes), reg_write_data, 16'hA000 + writes);
        writes++;
      end
    end
    check("drain_count", writes, 4);
    check("drain_overflow_sticky", host_overflow, 1);
    check("drain_level", host_fifo_level, 0);

    reset = 1'b1; tick(); reset = 1'b0;

    // Copper write held off by reg_busy, issued the cycle after it falls.
    drive(0, 0, 0, 1, 6'h15, 16'hD00D, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("stall%0d_we", c), reg_write_en, 0);
      check($sformatf("stall%0d_copper_ready", c), copper_ready, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    check("stall_issue_we", reg_write_en, 1);
    check("stall_issue_addr", reg_write_address, 6'h15);
    check("stall_issue_data", reg_write_data, 16'hD00D);
    check("stall_issue_src", reg_write_from_copper, 1);
    tick();
    check("stall_after_copper_ready", copper_ready, 1);

    // Reset with three host entries and a copper write pending.
    drive(1, 6'h2A, 16'h0101, 0, 0, 0, 1); tick();
    drive(1, 6'h2B, 16'h0202, 0, 0, 0, 1); tick();
    drive(1, 6'h2C, 16'h0303, 1, 6'h2F, 16'hFFFF, 1); tick();
    check("pre_reset_level", host_fifo_level, 3);
    check("pre_reset_copper_ready", copper_ready, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset_values("midreset");
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("post_reset%0d_we", c), reg_write_en, 0);
      check($sformatf("post_reset%0d_level", c), host_fifo_level, 0);
    end

    // Randomized traffic: alternating light and heavy reg_busy phases.
    for (int c = 0; c < 800; c++) begin
      reset           = ($urandom_range(0, 199) == 0);
      host_write_en   = $urandom_range(0, 1);
      host_address    = 6'($urandom);
      host_data       = 16'($urandom);
      copper_write_en = !m_hold_v && ($urandom_range(0, 2) == 0);
      copper_address  = 6'($urandom);
      copper_data     = 16'($urandom);
      reg_busy        = ((c / 50) % 2 == 1) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
      tick();
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vdp_reg_arbiter.md
# vdp_reg_arbiter

Shares the single VDP register-file write port between two requesters: the host CPU bus and the copper coprocessor. Host writes are buffered in a small FIFO. Copper writes pass through a one-entry holding register and take priority, because they are raster-timed. A starvation counter guarantees host progress. The block sits between the CPU peripheral decode, the copper and the VDP register file.

## Interface
Parameters:
- HOST_FIFO_DEPTH, 4, host FIFO entries; power of two, 2..16
- STARVE_LIMIT, 8, consecutive copper grants allowed while host entries are pending; 1..255

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- host_write_en  in  1  host write strobe, one entry per cycle
- host_address  in  6  host target register
- host_data  in  16  host write data
- host_ready  out  1  FIFO not full (registered)
- host_overflow  out  1  sticky; set when host_write_en arrives while host_ready=0
- host_fifo_level  out  $clog2(HOST_FIFO_DEPTH)+1  current FIFO occupancy
- copper_write_en  in  1  copper write strobe
- copper_address  in  6  copper target register
- copper_data  in  16  copper write data
- copper_ready  out  1  holding register empty (registered); copper must not strobe while low
- reg_busy  in  1  register file cannot accept a write this cycle
- reg_write_en  out  1  one-cycle write pulse to the register file
- reg_write_address  out  6  address for the write
- reg_write_data  out  16  data for the write
- reg_write_from_copper  out  1  source of the current write; valid only with reg_write_en

## Operation
- Host path: push on host_write_en && host_ready. host_write_en while full drops the write and sets host_overflow.
- Copper path: copper_write_en && copper_ready captures the address and data into the hold register and sets hold_valid. copper_ready = !hold_valid.
- copper_write_en while hold_valid: write dropped, no flag. This is a protocol violation; the bench asserts it never happens.
- Arbitration is evaluated each cycle from registered state. With reg_busy=1, there is no grant, reg_write_en<=0 and all state is held.
- Grant rules with reg_busy=0:
  - only hold_valid: copper granted
  - only FIFO non-empty: host granted
  - both pending: copper granted, unless starve_cnt==STARVE_LIMIT, in which case host is granted once
  - neither pending: reg_write_en<=0
- On a grant, register the winner's address and data into the outputs, set reg_write_en=1 and set reg_write_from_copper. Then pop that source: clear hold_valid, or advance the FIFO read pointer.
- starve_cnt is 8 bits:
  - +1 on each copper grant while the FIFO is non-empty, saturating at STARVE_LIMIT
  - reset to 0 on a host grant, or whenever the FIFO is empty
- Simultaneous push and pop on the FIFO in the same cycle is legal; the level is unchanged.
- Pointer wrap is modulo HOST_FIFO_DEPTH. Full is level==DEPTH and empty is level==0.
- Host writes are issued to the register file in FIFO order. Order between host and copper writes is set only by the grant rules.
- reg_write_address and reg_write_data hold their last value when reg_write_en=0.

## Timing
- Reset values: reg_write_en=0, reg_write_address=0, reg_write_data=0, reg_write_from_copper=0, host_ready=1, copper_ready=1, host_overflow=0, host_fifo_level=0, starve_cnt=0.
- Reset mid-operation discards all pending FIFO and hold entries. No write is issued in the cycle after reset.
- Latency: a strobe in cycle t gives earliest reg_write_en in cycle t+2, for either source.
- Copper back-to-back: copper_ready is 0 in cycle t+1 and returns to 1 in cycle t+2 if the write was granted in t+1.
- host_ready drops in the cycle after the push that fills the FIFO. It returns in the cycle after a pop from the full state.
- Throughput: at most one register write per cycle, and only while reg_busy=0.
- reg_busy is sampled in the same cycle as the grant decision. A write issued in cycle n means reg_busy was 0 in cycle n-1.

## Test plan
- Host only: 3 host writes (0x05←0x1234, 0x06←0x5678, 0x07←0x9ABC) in consecutive cycles, reg_busy=0 → reg_write_en in cycles t+2..t+4 in that order, reg_write_from_copper=0, level returns to 0.
- Copper priority: FIFO holding 2 entries and copper write 0x10←0xBEEF strobed at the same cycle → the copper write is issued first, followed by both host writes.
- Starvation: STARVE_LIMIT=2, FIFO holding 1 entry, copper strobing every 2 cycles → grants copper, copper, host, then copper; starve_cnt returns to 0.
- Full/overflow: DEPTH=4, reg_busy=1, 5 host strobes → host_ready=0 after the 4th, the 5th is dropped and host_overflow=1. Release reg_busy → exactly 4 writes, in order.
- Busy stall: copper write pending, reg_busy=1 for 10 cycles → no reg_write_en and copper_ready=0 throughout. The write is issued the cycle after reg_busy falls.
- Reset mid-operation: FIFO at level 3, hold_valid=1, pulse reset → all outputs at reset values, no writes issued afterward, level=0.
